contador_varredura: RTL and testbench
=====================================

Name: contador_varredura

Overview:
- Parametrised up/down position counter for the servo/position datapath. Successor of the single-step saturating vai/vem counter.
- Adds programmable step size, a configurable [MIN,MAX] range, and four movement modes: manual saturating, manual wrap, automatic ping-pong sweep, and hold.
- Adds a registered direction output and a registered one-cycle pulse at every sweep reversal or wrap.
- Sits between the control FSM (modo, tick) and the position/PWM logic.

Parameters:
- N, 7, width of position Q, D and passo.
- MIN, 0, lower position limit; 0 ≤ MIN < MAX ≤ 2^N-1.
- MAX, 99, upper position limit.
- MID, (MIN+MAX)/2, integer-truncated position flagged by meio.

Ports:
- clock  in  1  system clock, rising edge.
- zera_as  in  1  asynchronous reset, active-high.
- set_pos  in  1  synchronous load of D.
- vai  in  1  manual increment request.
- vem  in  1  manual decrement request.
- enable_mov  in  1  movement tick; no position change unless high.
- modo  in  2  00 manual-saturate, 01 manual-wrap, 10 auto sweep, 11 hold.
- passo  in  N  step size; 0 means no movement.
- D  in  N  load value.
- Q  out  N  current position, registered.
- dir  out  1  current sweep direction (1 = up), registered.
- volta  out  1  one-cycle pulse on reversal or wrap, registered.
- fim  out  1  Q==MAX, combinational.
- inicio  out  1  Q==MIN, combinational.
- meio  out  1  Q==MID, combinational.

Behaviour:
- One clock; reset is asynchronous and active-high. zera_as forces Q=MIN, dir=1, volta=0 immediately, independent of clock, including mid-sweep.
- Priority each edge: zera_as > set_pos > movement.
- Q only changes when set_pos=1, or when enable_mov=1 with an active mode condition below.
- volta defaults to 0 every cycle; it is 1 only on the cycle after a reversal or wrap edge.
- set_pos: Q <= D clamped to [MIN,MAX] (D<MIN gives MIN; D>MAX gives MAX). dir and volta are unchanged/0. No movement that cycle.
- All sums and differences use N+1-bit arithmetic; no intermediate overflow is permitted.
- modo 00 (manual-saturate):
  - vai&!vem: Q <= min(Q+passo, MAX).
  - vem&!vai: Q <= max(Q-passo, MIN).
  - vai&vem both high: hold.
  - dir follows the last accepted request: 1 on vai, 0 on vem.
- modo 01 (manual-wrap): range R = MAX-MIN+1; passo must be ≤ R.
  - vai: if Q+passo > MAX, Q <= Q+passo-R and volta pulses; else Q <= Q+passo.
  - vem: if Q < MIN+passo, Q <= Q-passo+R and volta pulses; else Q <= Q-passo.
  - vai&vem both high: hold.
- modo 10 (auto sweep): vai/vem ignored; each enable_mov tick moves one step in dir.
  - dir=1 and Q+passo ≥ MAX: Q <= MAX, dir <= 0, volta pulses.
  - dir=0 and Q ≤ MIN+passo: Q <= MIN, dir <= 1, volta pulses.
  - Otherwise Q moves by passo in dir.
  - Exact landing on a limit reverses on that same tick.
- modo 11 (hold): Q and dir frozen; set_pos still works.
- Mode change takes effect on the next edge. Q and dir are preserved across the change; the sweep resumes from the current Q and dir.
- passo=0: no movement and no volta in any mode.
- Out-of-range passo in wrap mode is undefined and is not tested.

Test Plan:
- Reset/flags: pulse zera_as asynchronously mid-sweep (Q=57, dir=0) -> Q=0, dir=1, inicio=1, volta=0 before the next edge.
- Manual saturate: N=7, MIN=0, MAX=99, passo=5, Q=97, vai tick -> Q=99, fim=1; further vai ticks keep Q=99. From Q=3, vem -> Q=0. vai&vem both high -> Q unchanged.
- Wrap: passo=5, Q=97, vai -> Q=2, volta=1 for exactly one cycle. Q=2, vem -> Q=97, volta=1. Q=49 -> meio=1.
- Auto sweep: passo=10, start Q=0, modo=10, 20 ticks -> Q sequence 0,10,…,90,99 (dir->0, volta), 89,…,9,0 (dir->1, volta). volta pulses exactly twice; ticks absent means no change.
- set_pos clamp/priority: MIN=10, MAX=90, D=5 with set_pos and vai same edge -> Q=10. D=120 -> Q=90. Mode 11 with enable_mov and vai -> Q unchanged.
- passo=0 in every mode with enable_mov high for 10 cycles -> Q, dir constant; volta never asserted.

Source files
------------

// File: rtl/contador_varredura.sv
// Up/down position counter with programmable step, [MIN,MAX] range and saturate/wrap/sweep/hold modes.
// Latency: Q, dir and volta update one clock after the request; fim/inicio/meio decode Q combinationally.
// Backpressure: none; enable_mov gates every movement and set_pos overrides movement on the same edge.
module contador_varredura #(
  parameter int N   = 7,
  parameter int MIN = 0,
  parameter int MAX = 99,
  parameter int MID = (MIN + MAX) / 2
) (
  input  logic         clock,
  input  logic         zera_as,
  input  logic         set_pos,
  input  logic         vai,
  input  logic         vem,
  input  logic         enable_mov,
  input  logic [1:0]   modo,
  input  logic [N-1:0] passo,
  input  logic [N-1:0] D,
  output logic [N-1:0] Q,
  output logic         dir,
  output logic         volta,
  output logic         fim,
  output logic         inicio,
  output logic         meio
);

  typedef enum logic [1:0] {
    MODO_SAT   = 2'b00,
    MODO_WRAP  = 2'b01,
    MODO_SWEEP = 2'b10,
    MODO_HOLD  = 2'b11
  } modo_t;

  // One extra bit so Q+passo, Q+R and MIN+passo never overflow.
  localparam logic [N:0] MIN_W = (N+1)'(MIN);
  localparam logic [N:0] MAX_W = (N+1)'(MAX);
  localparam logic [N:0] R_W   = (N+1)'(MAX - MIN + 1);
  localparam logic [N:0] MID_W = (N+1)'(MID);

  logic [N-1:0] q_q, q_d;
  logic         dir_q, dir_d;
  logic         volta_q, volta_d;

  logic [N:0] q_ext, p_ext, d_ext;
  logic [N:0] soma, dif, wrap_up, wrap_dn, min_p;
  logic       pedido_sobe, pedido_desce;
  modo_t      modo_e;

  // Next-state for position, direction and the reversal/wrap pulse.
  always_comb begin
    q_d          = q_q;
    dir_d        = dir_q;
    volta_d      = 1'b0;
    modo_e       = modo_t'(modo);
    q_ext        = {1'b0, q_q};
    p_ext        = {1'b0, passo};
    d_ext        = {1'b0, D};
    soma         = q_ext + p_ext;
    dif          = q_ext - p_ext;
    wrap_up      = soma - R_W;
    wrap_dn      = q_ext + R_W - p_ext;
    min_p        = MIN_W + p_ext;
    pedido_sobe  = vai & ~vem;
    pedido_desce = vem & ~vai;

    if (set_pos) begin
      if (d_ext < MIN_W)      q_d = MIN_W[N-1:0];
      else if (d_ext > MAX_W) q_d = MAX_W[N-1:0];
      else                    q_d = D;
    end else if (enable_mov && (passo != '0)) begin
      unique case (modo_e)
        MODO_SAT: begin
          if (pedido_sobe) begin
            q_d   = (soma > MAX_W) ? MAX_W[N-1:0] : soma[N-1:0];
            dir_d = 1'b1;
          end else if (pedido_desce) begin
            q_d   = (q_ext < min_p) ? MIN_W[N-1:0] : dif[N-1:0];
            dir_d = 1'b0;
          end
        end
        MODO_WRAP: begin
          // dir tracks the last accepted request here as well, so a later sweep continues that way.
          if (pedido_sobe) begin
            dir_d = 1'b1;
            if (soma > MAX_W) begin
              q_d     = wrap_up[N-1:0];
              volta_d = 1'b1;
            end else begin
              q_d = soma[N-1:0];
            end
          end else if (pedido_desce) begin
            dir_d = 1'b0;
            if (q_ext < min_p) begin
              q_d     = wrap_dn[N-1:0];
              volta_d = 1'b1;
            end else begin
              q_d = dif[N-1:0];
            end
          end
        end
        MODO_SWEEP: begin
          // Reaching or overshooting a limit parks on it and reverses on the same tick.
          if (dir_q) begin
            if (soma >= MAX_W) begin
              q_d     = MAX_W[N-1:0];
              dir_d   = 1'b0;
              volta_d = 1'b1;
            end else begin
              q_d = soma[N-1:0];
            end
          end else begin
            if (q_ext <= min_p) begin
              q_d     = MIN_W[N-1:0];
              dir_d   = 1'b1;
              volta_d = 1'b1;
            end else begin
              q_d = dif[N-1:0];
            end
          end
        end
        MODO_HOLD: begin
          q_d = q_q;
        end
      endcase
    end
  end

  // State registers; zera_as returns to MIN counting up regardless of the clock.
  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as) begin
      q_q     <= MIN_W[N-1:0];
      dir_q   <= 1'b1;
      volta_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      dir_q   <= dir_d;
      volta_q <= volta_d;
    end
  end

  assign Q      = q_q;
  assign dir    = dir_q;
  assign volta  = volta_q;
  assign fim    = ({1'b0, q_q} == MAX_W);
  assign inicio = ({1'b0, q_q} == MIN_W);
  assign meio   = ({1'b0, q_q} == MID_W);

endmodule

// File: tb/tb_contador_varredura.sv
// Bench for contador_varredura: default range [0,99] plus a [10,90] instance for clamping.
// Latency: checks sample one time unit after the rising edge that follows each drive.
// Backpressure: none; expected values queue at drive time and are popped after the edge.
module tb_contador_varredura;

  localparam int N = 7;

  logic         clock = 1'b0;
  logic         zera_as, set_pos, vai, vem, enable_mov;
  logic [1:0]   modo;
  logic [N-1:0] passo, D;
  logic [N-1:0] qa, qb;
  logic         dira, dirb, voltaa, voltab;
  logic         fima, fimb, inicioa, iniciob, meioa, meiob;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       sp, vai, vem, en;
    logic [1:0] modo;
    int         passo, d;
    int         eq;
    logic       edir, evolta;
  } vec_t;

  typedef struct {
    int   eq;
    logic edir, evolta;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[16];

  always #5 clock = ~clock;

  contador_varredura #(.N(N)) dut_a (
    .clock(clock), .zera_as(zera_as), .set_pos(set_pos), .vai(vai), .vem(vem),
    .enable_mov(enable_mov), .modo(modo), .passo(passo), .D(D),
    .Q(qa), .dir(dira), .volta(voltaa), .fim(fima), .inicio(inicioa), .meio(meioa)
  );

  contador_varredura #(.N(N), .MIN(10), .MAX(90)) dut_b (
    .clock(clock), .zera_as(zera_as), .set_pos(set_pos), .vai(vai), .vem(vem),
    .enable_mov(enable_mov), .modo(modo), .passo(passo), .D(D),
    .Q(qb), .dir(dirb), .volta(voltab), .fim(fimb), .inicio(iniciob), .meio(meiob)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic sp, input logic va, input logic ve, input logic en,
                              input logic [1:0] m, input int p, input int d,
                              input int eq, input logic edir, input logic ev);
    vec_t v;
    v.sp = sp; v.vai = va; v.vem = ve; v.en = en; v.modo = m;
    v.passo = p; v.d = d; v.eq = eq; v.edir = edir; v.evolta = ev;
    return v;
  endfunction

  // Drive one cycle, queue its expectation, then pop and compare after the edge.
  task automatic step(input string name, input vec_t v);
    exp_t e, got;
    @(negedge clock);
    set_pos = v.sp; vai = v.vai; vem = v.vem; enable_mov = v.en;
    modo = v.modo; passo = N'(v.passo); D = N'(v.d);
    e.eq = v.eq; e.edir = v.edir; e.evolta = v.evolta;
    sb.push_back(e);
    @(posedge clock);
    #1;
    got = sb.pop_front();
    chk({name, ".Q"},     int'(qa),     got.eq);
    chk({name, ".dir"},   int'(dira),   int'(got.edir));
    chk({name, ".volta"}, int'(voltaa), int'(got.evolta));
    chk({name, ".fim"},    int'(fima),    (got.eq == 99) ? 1 : 0);
    chk({name, ".inicio"}, int'(inicioa), (got.eq == 0)  ? 1 : 0);
    chk({name, ".meio"},   int'(meioa),   (got.eq == 49) ? 1 : 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    zera_as = 1'b1;
    #2;
    zera_as = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int vcount;
    int eq;
    logic edir;

    // Rows: set_pos vai vem en modo passo D | Q dir volta
    tbl[0]  = mk(1,0,0,0, 2'b00, 5, 97,  97, 1, 0);
    tbl[1]  = mk(0,1,0,1, 2'b00, 5,  0,  99, 1, 0);
    tbl[2]  = mk(0,1,0,1, 2'b00, 5,  0,  99, 1, 0);
    tbl[3]  = mk(1,0,0,0, 2'b00, 5,  3,   3, 1, 0);
    tbl[4]  = mk(0,0,1,1, 2'b00, 5,  0,   0, 0, 0);
    tbl[5]  = mk(0,1,1,1, 2'b00, 5,  0,   0, 0, 0);
    tbl[6]  = mk(0,1,0,0, 2'b00, 5,  0,   0, 0, 0);
    tbl[7]  = mk(1,0,0,0, 2'b01, 5, 97,  97, 0, 0);
    tbl[8]  = mk(0,1,0,1, 2'b01, 5,  0,   2, 1, 1);
    tbl[9]  = mk(0,0,0,0, 2'b01, 5,  0,   2, 1, 0);
    tbl[10] = mk(0,0,1,1, 2'b01, 5,  0,  97, 0, 1);
    tbl[11] = mk(0,0,1,1, 2'b01, 5,  0,  92, 0, 0);
    tbl[12] = mk(1,0,0,0, 2'b01, 5, 49,  49, 0, 0);
    tbl[13] = mk(0,1,0,1, 2'b11, 5,  0,  49, 0, 0);
    tbl[14] = mk(0,0,1,1, 2'b01, 5,  0,  44, 0, 0);
    tbl[15] = mk(0,1,0,1, 2'b01, 5,  0,  49, 1, 0);

    zera_as = 1'b1; set_pos = 0; vai = 0; vem = 0; enable_mov = 0;
    modo = 2'b00; passo = '0; D = '0;
    #12;
    zera_as = 1'b0;
    #1;
    chk("reset.Q",      int'(qa),      0);
    chk("reset.dir",    int'(dira),    1);
    chk("reset.volta",  int'(voltaa),  0);
    chk("reset.inicio", int'(inicioa), 1);
    chk("reset.qb",     int'(qb),      10);

    for (int i = 0; i < 16; i++) step($sformatf("tbl%0d", i), tbl[i]);

    // Clamping and set_pos priority over vai on the [10,90] instance.
    step("clamp_lo", mk(1,1,0,1, 2'b00, 5, 5, 5, 1, 0));
    chk("clamp_lo.qb",     int'(qb),      10);
    chk("clamp_lo.inicio", int'(iniciob), 1);
    step("clamp_hi", mk(1,0,0,1, 2'b00, 5, 120, 99, 1, 0));
    chk("clamp_hi.qb",  int'(qb),   90);
    chk("clamp_hi.fim", int'(fimb), 1);
    step("hold_b", mk(0,1,0,1, 2'b11, 5, 0, 99, 1, 0));
    chk("hold_b.qb", int'(qb), 90);

    // Auto sweep 0 -> 99 -> 0 with passo=10.
    do_reset();
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 9)       begin eq = 10 * (i + 1);    edir = 1; end
      else if (i == 9) begin eq = 99;              edir = 0; end
      else if (i < 19) begin eq = 89 - 10*(i - 10); edir = 0; end
      else             begin eq = 0;               edir = 1; end
      step($sformatf("sweep%0d", i),
           mk(0,1,0,1, 2'b10, 10, 0, eq, edir, (i == 9 || i == 19) ? 1'b1 : 1'b0));
      if (voltaa) vcount++;
    end
    chk("sweep.volta_count", vcount, 2);
    step("sweep_notick", mk(0,0,0,0, 2'b10, 10, 0, 0, 1, 0));

    // Asynchronous reset mid-sweep at Q=57, dir=0.
    step("pre_async_a", mk(1,0,0,0, 2'b00, 5, 72, 72, 1, 0));
    step("pre_async_b", mk(0,0,1,1, 2'b00, 5,  0, 67, 0, 0));
    step("pre_async_c", mk(0,0,0,1, 2'b10, 10, 0, 57, 0, 0));
    #3;
    zera_as = 1'b1;
    #1;
    chk("async.Q",      int'(qa),      0);
    chk("async.dir",    int'(dira),    1);
    chk("async.inicio", int'(inicioa), 1);
    chk("async.volta",  int'(voltaa),  0);
    zera_as = 1'b0;

    // passo=0 freezes position and direction in every mode.
    step("p0_load", mk(1,0,0,0, 2'b00, 0, 40, 40, 1, 0));
    vcount = 0;
    for (int m = 0; m < 4; m++) begin
      for (int k = 0; k < 10; k++) begin
        step($sformatf("p0_m%0d_%0d", m, k),
             mk(0, k[0], ~k[0], 1, 2'(m), 0, 0, 40, 1, 0));
        if (voltaa) vcount++;
      end
    end
    chk("p0.volta_count", vcount, 0);

    chk("sb.empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
